// File: rtl/tone_seq_pkg.sv
// Shared state type, constants and saturation helper for the multi-voice tone sequencer.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  localparam int REST_HALF_PERIOD = 0;
  localparam int ROM_LATENCY      = 1;

  // Clamp a signed value into the range of an out_w-bit two's complement word.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] value,
                                                    input int unsigned        out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave track: latches a half-period per song step and emits a signed
// +/-AMPLITUDE contribution (zero for a rest or while muted).
module tone_voice
  import tone_seq_pkg::*;
#(
  parameter int HALF_PERIOD_W = 19,
  parameter int CONTRIB_W     = 34,
  parameter int AMPLITUDE     = 100000000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     latch,
  input  logic                     run,
  input  logic                     mute,
  input  logic [HALF_PERIOD_W-1:0] half_period_in,
  output logic [CONTRIB_W-1:0]     contribution
);

  localparam logic [CONTRIB_W-1:0] AMP_POS = CONTRIB_W'(AMPLITUDE);
  localparam logic [CONTRIB_W-1:0] AMP_NEG = CONTRIB_W'(0) - AMP_POS;

  logic [HALF_PERIOD_W-1:0] half_period;
  logic [HALF_PERIOD_W-1:0] phase;
  logic                     tone;
  logic                     is_rest;

  assign is_rest = (half_period == HALF_PERIOD_W'(REST_HALF_PERIOD));

  // Phase runs 0..half_period and flips the tone bit on wrap, so a full period is 2*(hp+1).
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      half_period <= '0;
      phase       <= '0;
      tone        <= 1'b0;
    end else if (clear) begin
      half_period <= '0;
      phase       <= '0;
      tone        <= 1'b0;
    end else if (latch) begin
      half_period <= half_period_in;
      phase       <= '0;
      tone        <= 1'b0;
    end else if (run && !is_rest) begin
      if (phase == half_period) begin
        phase <= '0;
        tone  <= ~tone;
      end else begin
        phase <= phase + HALF_PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    contribution = '0;
    if (!mute && !is_rest) begin
      contribution = tone ? AMP_POS : AMP_NEG;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice square-wave song player: control FSM, shared step address, per-track voices
// and a registered saturating mixer. Build macro TONE_SEQ_MIC_MIX_EN adds a mixed-in mic input.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int NUM_VOICES    = 2,
  parameter int HALF_PERIOD_W = 19,
  parameter int SONG_LEN      = 1000,
  parameter int ADDR_W        = $clog2(SONG_LEN),
  parameter int BEAT_CYCLES   = 2500000,
  parameter int AMPLITUDE     = 100000000,
  parameter int SAMPLE_W      = 32
) (
  input  logic                                CLOCK_50,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                stop,
  input  logic                                pause,
  input  logic                                loop_en,
  output logic [ADDR_W-1:0]                   rom_addr,
  input  logic [NUM_VOICES*HALF_PERIOD_W-1:0] rom_data,
  input  logic                                audio_out_allowed,
`ifdef TONE_SEQ_MIC_MIX_EN
  input  logic [SAMPLE_W-1:0]                 mic_in,
  input  logic                                mic_valid,
`endif
  output logic                                write_audio_out,
  output logic [SAMPLE_W-1:0]                 sample_out,
  output logic                                busy,
  output logic                                done
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_LATCH = BEAT_W'(ROM_LATENCY);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SONG_LEN - 1);

  seq_state_t              state;
  seq_state_t              next_state;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    playing;
  logic                    start_action;
  logic                    beat_term;
  logic                    song_end;
  logic                    voice_latch;
  logic [SUM_W-1:0]        voice_contrib [NUM_VOICES];
  logic signed [SUM_W-1:0] mix_sum;
  logic [SAMPLE_W-1:0]     sample_next;
  logic                    write_next;

  always_comb begin
    playing      = (state == PLAY);
    start_action = start && !stop;
    beat_term    = playing && (beat_cnt == BEAT_LAST);
    song_end     = beat_term && (rom_addr == ADDR_LAST) && !loop_en;
    voice_latch  = playing && (beat_cnt == BEAT_LATCH) && !start_action && !stop;
  end

  // stop beats start; a start samples pause so it can land directly in PAUSE.
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = pause ? PAUSE : PLAY;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        PLAY: begin
          if (song_end) begin
            next_state = IDLE;
          end else if (pause) begin
            next_state = PAUSE;
          end
        end
        PAUSE: begin
          if (!pause) begin
            next_state = PLAY;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign busy = (state == PLAY) || (state == PAUSE);

  // Beat and step counters only advance in PLAY, which is what freezes them during a pause.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
      rom_addr <= '0;
    end else if (start_action) begin
      beat_cnt <= '0;
      rom_addr <= '0;
    end else if (playing && !stop) begin
      if (beat_term) begin
        beat_cnt <= '0;
        if (rom_addr < ADDR_LAST) begin
          rom_addr <= rom_addr + ADDR_W'(1);
        end else if (loop_en) begin
          rom_addr <= '0;
        end
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .HALF_PERIOD_W (HALF_PERIOD_W),
      .CONTRIB_W     (SUM_W),
      .AMPLITUDE     (AMPLITUDE)
    ) u_voice (
      .CLOCK_50       (CLOCK_50),
      .resetn         (resetn),
      .clear          (start_action),
      .latch          (voice_latch),
      .run            (playing),
      .mute           (!playing),
      .half_period_in (rom_data[v*HALF_PERIOD_W +: HALF_PERIOD_W]),
      .contribution   (voice_contrib[v])
    );
  end

`ifdef TONE_SEQ_MIC_MIX_EN
  logic [SAMPLE_W-1:0] mic_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mic_q <= '0;
    end else if (mic_valid) begin
      mic_q <= mic_in;
    end
  end

  assign write_next = audio_out_allowed & mic_valid;
`else
  assign write_next = audio_out_allowed;
`endif

  // Full-width sum cannot overflow; saturation happens only when narrowing to SAMPLE_W.
  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + $signed(voice_contrib[v]);
    end
`ifdef TONE_SEQ_MIC_MIX_EN
    mix_sum = mix_sum + SUM_W'($signed(mic_q));
`endif
    sample_next = SAMPLE_W'(sat_resize(64'(mix_sum), SAMPLE_W));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sample_out      <= '0;
      write_audio_out <= 1'b0;
      done            <= 1'b0;
    end else begin
      sample_out      <= sample_next;
      write_audio_out <= write_next;
      done            <= song_end && !start && !stop;
    end
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised multi-voice square-wave song player. Successor to the single-voice ROM tone generator.
- NUM_VOICES parallel tracks share one song step address. Each track's ROM word gives a half-period in clock cycles.
- Voices are mixed with saturation into one signed sample for the Audio_Controller write path.
- Adds start/stop/pause control, a loop/one-shot mode, rests, and a done pulse.

Parameters:
- NUM_VOICES, 2, number of parallel tone tracks (1..8)
- HALF_PERIOD_W, 19, width of the ROM half-period word
- SONG_LEN, 1000, number of steps in the song
- ADDR_W, $clog2(SONG_LEN), ROM address width
- BEAT_CYCLES, 2500000, clock cycles per song step
- AMPLITUDE, 100000000, per-voice peak magnitude (positive, fits SAMPLE_W-1 bits)
- SAMPLE_W, 32, output sample width, two's complement

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: (re)start the song at step 0
- stop  in  1  single-cycle pulse: abort to idle
- pause  in  1  level: freeze playback while high
- loop_en  in  1  1 = wrap to step 0 after the last step; 0 = stop
- rom_addr  out  ADDR_W  step address shared by all track ROMs
- rom_data  in  NUM_VOICES*HALF_PERIOD_W  track half-periods; voice v at [v*HALF_PERIOD_W +: HALF_PERIOD_W]; valid exactly 1 cycle after rom_addr changes
- audio_out_allowed  in  1  Audio_Controller output FIFO has space
- write_audio_out  out  1  sample write strobe
- sample_out  out  SAMPLE_W  mixed signed sample
- busy  out  1  high in PLAY or PAUSE
- done  out  1  one-cycle pulse when a one-shot song completes

Behaviour:
- Reset:
  - state IDLE; rom_addr=0; beat counter 0.
  - All voice half-periods, phase counters and tone bits are 0.
  - sample_out=0, busy=0, done=0, write_audio_out=0.
- States are IDLE, PLAY and PAUSE.
  - IDLE -start-> PLAY.
  - PLAY -pause-> PAUSE.
  - PAUSE -!pause-> PLAY.
  - Any state -stop-> IDLE.
  - start in PLAY or PAUSE restarts from step 0.
  - stop has priority over start.
  - pause sampled high in the start cycle enters PAUSE immediately after the restart.
- Start action:
  - rom_addr=0, beat counter=0.
  - All voice half-periods are cleared (silent until the first latch).
- Beat counter (PLAY only):
  - Counts 0..BEAT_CYCLES-1.
  - At count==1, every voice latches its rom_data slice, clears its phase counter and sets its tone bit to 0.
  - At count==BEAT_CYCLES-1, the counter returns to 0.
  - At that same terminal count, if rom_addr<SONG_LEN-1, rom_addr increments.
  - Otherwise: loop_en=1 sets rom_addr=0 and play continues; loop_en=0 moves to IDLE with done=1 for one cycle.
  - Each step therefore sounds exactly BEAT_CYCLES cycles, offset by 1 cycle.
- Voice:
  - Half-period value 0 = rest; contributes 0.
  - Otherwise the phase counter counts 0..hp. At hp it resets to 0 and the tone bit toggles, giving a full period of 2*(hp+1) cycles.
  - Contribution is +AMPLITUDE if the tone bit is 1, else -AMPLITUDE, sign-extended to SAMPLE_W+$clog2(NUM_VOICES)+1 bits.
- Pause: beat counter, rom_addr and voice phase are held; the mixer treats all voices as rests (silence).
- Mixer:
  - Sums all contributions at full width, then saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Registered: sample_out reflects voice state from the previous cycle (1-cycle latency).
  - sample_out=0 in IDLE and PAUSE.
- Handshake:
  - write_audio_out = audio_out_allowed, registered alongside sample_out.
  - Written silence keeps the FIFO fed in idle.
  - Never asserted in reset.
- Reset asserted mid-song returns immediately to reset values; nothing resumes after reset release without a start.

Optional Feature:
- Macro TONE_SEQ_MIC_MIX_EN.
- Defined:
  - Adds input ports mic_in (SAMPLE_W, signed) and mic_valid.
  - mic_in, latched when mic_valid is high, is added into the mixer sum before saturation in all states.
  - In that build write_audio_out = audio_out_allowed & mic_valid.
- Undefined: no mic ports; the mixer uses voices only.

Decomposition:
- Package tone_seq_pkg:
  - state enum (IDLE/PLAY/PAUSE)
  - REST_HALF_PERIOD=0
  - ROM_LATENCY=1
  - saturating-resize function
- Sub-module tone_voice:
  - one per track
  - contains half-period register, phase counter, tone bit, latch/hold/mute inputs and signed contribution output
- The top holds the FSM, beat/address counters, mixer and handshake.

Test Plan:
Common bench parameters: NUM_VOICES=2, SONG_LEN=4, BEAT_CYCLES=20, AMPLITUDE=1000, SAMPLE_W=16; ROM model with 1-cycle latency.
- Reset then idle with audio_out_allowed=1 -> sample_out=0, write_audio_out=1, busy=0, rom_addr=0.
- start, voice0 hp=3, voice1 hp=0 -> voice0 toggles every 4 cycles; sample alternates +1000/-1000; rom_addr steps 0,1,2,3 every 20 cycles.
- loop_en=0 -> exactly one done pulse on the cycle after step 3's terminal count; then IDLE and sample_out=0. With loop_en=1 -> rom_addr wraps 3->0, no done.
- AMPLITUDE=20000, both voices in phase -> sum 40000 saturates to 32767; both negative -> -32768.
- pause mid-step for 7 cycles -> sample_out=0 while paused; beat count and rom_addr frozen; the step resumes with its remaining cycles.
- start and stop in the same cycle during PLAY -> IDLE. Reset pulse mid-step -> all outputs return to reset values asynchronously.
